// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: ALU, optional iterative multiplier, EXE/MEM register
// Optional multiplier enabled by defining EXE_MUL_EN.
module exe_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic [4:0]  edestReg,
  input  logic [31:0] eqa,
  input  logic [31:0] eqb,
  input  logic [31:0] eimm32,
  output logic        stall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mdestReg,
  output logic [31:0] malu,
  output logic [31:0] mqb
);

  logic [31:0] w_b;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_stall;

  assign w_b = ealuimm ? eimm32 : eqb;

  always_comb begin
    w_alu = 32'd0;
    case (ealuc)
      4'b0000: w_alu = eqa & w_b;
      4'b0001: w_alu = eqa | w_b;
      4'b0011: w_alu = eqa ^ w_b;
      4'b1100: w_alu = ~(eqa | w_b);
      4'b0010: w_alu = eqa + w_b;
      4'b0110: w_alu = eqa - w_b;
      4'b0111: w_alu = {31'd0, $signed(eqa) < $signed(w_b)};
      4'b0100: w_alu = w_b << eqa[4:0];
      4'b0101: w_alu = w_b >> eqa[4:0];
      default: w_alu = 32'd0;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic        w_mul_start;

  assign w_mul_start = (r_state == S_IDLE) && (ealuc == 4'b1000);
  // Gated by resetn so stall reads 0 while reset is held, even with MUL presented.
  assign w_stall     = resetn && (w_mul_start || (r_state == S_BUSY));
  assign w_result    = (r_state == S_DONE) ? r_acc : w_alu;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= eqa;
            r_mplier <= w_b;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == 6'(MUL_CYCLES - 1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_stall  = 1'b0;
  assign w_result = w_alu;
`endif

  assign stall = w_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mdestReg <= 5'd0;
      malu     <= 32'd0;
      mqb      <= 32'd0;
    end else if (w_stall) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mdestReg <= 5'd0;
      malu     <= 32'd0;
      mqb      <= 32'd0;
    end else begin
      mwreg    <= ewreg;
      mm2reg   <= em2reg;
      mwmem    <= ewmem;
      mdestReg <= edestReg;
      malu     <= w_result;
      mqb      <= eqb;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - randomized self-checking bench for exe_stage against a behavioural model
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  edestReg;
  logic [31:0] eqa, eqb, eimm32;
  logic        stall, mwreg, mm2reg, mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] malu, mqb;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk(clk), .resetn(resetn), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ealuimm(ealuimm), .edestReg(edestReg), .eqa(eqa), .eqb(eqb),
    .eimm32(eimm32), .stall(stall), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mdestReg(mdestReg), .malu(malu), .mqb(mqb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit mul_enabled();
`ifdef EXE_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: operation table evaluated with plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd3:  return a ^ b;
      4'd12: return ~(a | b);
      4'd2:  return 32'(longint'(a) + longint'(b));
      4'd6:  return 32'(longint'(a) - longint'(b));
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return 32'(longint'(b) * (longint'(1) << a[4:0]));
      4'd5:  return b / (32'd1 << a[4:0]);
      4'd8:  return mul_enabled() ? 32'(longint'(a) * longint'(b)) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic wr, input logic m2r, input logic wm, input logic [3:0] op,
                       input logic imm_sel, input logic [4:0] dst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    ewreg = wr; em2reg = m2r; ewmem = wm; ealuc = op; ealuimm = imm_sel;
    edestReg = dst; eqa = a; eqb = b; eimm32 = imm;
  endtask

  // Waits out any stall (checking bubbles), then checks the captured instruction.
  task automatic wait_and_check();
    int cyc, exp_cyc;
    logic [31:0] bop;
    #1;
    exp_cyc = (mul_enabled() && ealuc == 4'd8) ? 33 : 0;
    cyc = 0;
    while (stall === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
      check("bubble_mwreg", {31'd0, mwreg}, 32'd0);
      check("bubble_malu", malu, 32'd0);
    end
    check("stall_cycles", cyc, exp_cyc);
    bop = ealuimm ? eimm32 : eqb;
    @(posedge clk); #1;
    check("malu", malu, ref_result(ealuc, eqa, bop));
    check("mwreg", {31'd0, mwreg}, {31'd0, ewreg});
    check("mm2reg", {31'd0, mm2reg}, {31'd0, em2reg});
    check("mwmem", {31'd0, mwmem}, {31'd0, ewmem});
    check("mdestReg", {27'd0, mdestReg}, {27'd0, edestReg});
    check("mqb", mqb, eqb);
  endtask

  task automatic run_instr(input logic wr, input logic m2r, input logic wm, input logic [3:0] op,
                           input logic imm_sel, input logic [4:0] dst, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm);
    drive(wr, m2r, wm, op, imm_sel, dst, a, b, imm);
    wait_and_check();
  endtask

  initial begin
    logic [3:0] codes [11];
    codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd15};

    resetn = 1'b0;
    drive(0, 0, 0, 4'd0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mwreg", {31'd0, mwreg}, 32'd0);
    check("rst_mm2reg", {31'd0, mm2reg}, 32'd0);
    check("rst_mwmem", {31'd0, mwmem}, 32'd0);
    check("rst_mdest", {27'd0, mdestReg}, 32'd0);
    check("rst_malu", malu, 32'd0);
    check("rst_mqb", mqb, 32'd0);
    @(posedge clk); #1;

    // Directed cases: lw address, SUB, SLT, unsupported code.
    run_instr(1, 1, 0, 4'b0010, 1, 5'd3, 32'h100, 32'h0, 32'h4);
    check("lw_addr_abs", malu, 32'h104);
    run_instr(1, 0, 0, 4'b0110, 0, 5'd4, 32'd5, 32'd7, 32'h0);
    check("sub_abs", malu, 32'hFFFF_FFFE);
    run_instr(1, 0, 0, 4'b0111, 0, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'h0);
    check("slt_abs", malu, 32'd1);
    run_instr(1, 0, 0, 4'b1111, 0, 5'd6, 32'h1234, 32'h5678, 32'h0);
    check("undef_abs", malu, 32'd0);

    // MUL and the following nop: no duplicate write.
    run_instr(1, 0, 0, 4'b1000, 0, 5'd9, 32'h12345, 32'h100, 32'h0);
    check("mul_abs", malu, mul_enabled() ? 32'h0123_4500 : 32'd0);
    run_instr(0, 0, 0, 4'b0000, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    run_instr(1, 0, 0, 4'b1000, 0, 5'd2, 32'd3, 32'd4, 32'h0);

    // Reset in the middle of a multiply, MUL still presented afterwards.
    drive(1, 0, 0, 4'b1000, 0, 5'd7, 32'hDEAD_BEEF, 32'h0000_F00D, 32'h0);
    repeat (11) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_mwreg", {31'd0, mwreg}, 32'd0);
    check("midrst_malu", malu, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    wait_and_check();

    // Randomized instruction stream.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = codes[$urandom_range(0, 10)];
      if (op == 4'd15) op = 4'($urandom);
      run_instr(1'($urandom), 1'($urandom), 1'($urandom), op, 1'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Selects the ALU B operand (qb or sign-extended immediate) and performs the ALU operation selected by ealuc.
- Includes an iterative 32-cycle multiplier that stalls the front end while it runs.
- Registers the result and the control signals into the EXE/MEM pipeline register, which feeds data memory.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations in BUSY; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ewreg  in  1  register-write enable from ID/EXE.
- em2reg  in  1  memory-to-register select from ID/EXE.
- ewmem  in  1  memory-write enable from ID/EXE.
- ealuc  in  4  ALU operation code.
- ealuimm  in  1  1 = B operand is eimm32; 0 = B operand is eqb.
- edestReg  in  5  destination register number.
- eqa  in  32  A operand.
- eqb  in  32  register rt value; also the store data.
- eimm32  in  32  sign-extended immediate.
- stall  out  1  1 = upstream (PC, IF/ID, ID/EXE) must hold.
- mwreg  out  1  registered ewreg.
- mm2reg  out  1  registered em2reg.
- mwmem  out  1  registered ewmem.
- mdestReg  out  5  registered destination register.
- malu  out  32  registered ALU result (memory address for lw/sw).
- mqb  out  32  registered eqb (store data).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- While resetn=0:
  - all m* outputs = 0;
  - stall = 0;
  - FSM = IDLE;
  - multiplier accumulator, multiplicand, multiplier and counter cleared.
  - Reset during BUSY abandons the multiply. After reset release the FSM is IDLE, so a MUL still presented on ealuc restarts from scratch.
- B operand: b = ealuimm ? eimm32 : eqb.
- ALU codes (32-bit, wrap-around, no overflow detection):
  - 0000 AND
  - 0001 OR
  - 0011 XOR
  - 1100 NOR
  - 0010 ADD (a+b)
  - 0110 SUB (a-b)
  - 0111 SLT: 1 if signed a<b, else 0
  - 0100 SLL: b << a[4:0]
  - 0101 SRL: b >> a[4:0]
  - 1000 MUL: low 32 bits of a*b, unsigned shift-add
  - any other code: result 0.
- Non-MUL ops: combinational, 1-cycle latency. Result appears on malu at the next rising edge; stall stays 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - if ealuc=1000: stall=1 combinationally; load mcand=a, mplier=b, acc=0, cnt=0; next = BUSY.
    - else: stall=0.
  - BUSY:
    - stall=1 each cycle;
    - if mplier[0]=1, acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++;
    - when cnt reaches MUL_CYCLES-1 on this edge, next = DONE.
  - DONE: stall=0; result = acc; next = IDLE unconditionally. The same MUL instruction, still present on ealuc, is not restarted.
  - MUL timing: stall is high for exactly 33 cycles (1 IDLE + 32 BUSY). The result is captured into malu at the end of the DONE cycle.
- EXE/MEM register:
  - In any cycle with stall=1, it captures a bubble: mwreg=0, mwmem=0, mm2reg=0, mdestReg=0, malu=0, mqb=0.
  - Otherwise it captures the e* controls, eqb, and the ALU/MUL result.
  - No instruction is ever written twice.
- Upstream contract: all e* inputs stay stable while stall=1. The block does not latch eqb/edestReg separately.
- ewreg=1 with edestReg=0 is passed through unchanged; register 0 protection is handled at writeback.

Optional Feature:
- Macro: EXE_MUL_EN.
- Defined: multiplier FSM and code 1000 behave as specified above.
- Undefined:
  - no FSM or multiplier registers exist;
  - stall is tied to 0;
  - code 1000 yields result 0 with 1-cycle latency, like any unsupported code.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release with nothing presented -> all m* = 0, stall = 0.
- lw immediate: ealuc=0010, ealuimm=1, eqa=0x100, eimm32=0x4, ewreg=1, em2reg=1, edestReg=3 -> next edge: malu=0x104, mwreg=1, mm2reg=1, mdestReg=3.
- Register ops:
  - SUB eqa=5, eqb=7 -> malu=0xFFFFFFFE.
  - SLT eqa=0xFFFFFFFF, eqb=1 -> malu=1.
  - ealuc=1111 -> malu=0.
- MUL (EXE_MUL_EN defined): eqa=0x12345, eqb=0x100, ewreg=1, edestReg=9 -> stall high for exactly 33 cycles with bubbles (mwreg=0) in EXE/MEM. Next edge after stall falls: malu=0x01234500, mwreg=1, mdestReg=9. No second write on the following cycle.
- Reset mid-MUL: pull resetn low at cycle 10 of BUSY, release with MUL still presented -> stall restarts and lasts 33 cycles; correct product results.
- EXE_MUL_EN undefined: ealuc=1000, eqa=3, eqb=4 -> stall never asserted; malu=0 on next edge.
